// File: rtl/keypad_scan_controller.sv
// keypad_scan_controller: 4x4 keypad column scanner with tick-paced press and release debounce.
module keypad_scan_controller #(
    parameter int DEBOUNCE_TICKS = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       tick,
    input  logic [3:0] rows_n,
    output logic [3:0] cols_n,
    output logic [3:0] key_code,
    output logic       key_valid,
    output logic       key_held
);
    localparam int CW = $clog2(DEBOUNCE_TICKS + 1);
    localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_TICKS - 1);
    typedef enum logic [1:0] {SCAN, DEB_PRESS, HELD, DEB_REL} state_t;
    state_t state, state_nxt;
    logic [3:0] rows_meta, rs, code_nxt;
    logic [1:0] col_idx, col_nxt, row, row_nxt, row_lo;
    logic [CW-1:0] cnt, cnt_nxt;
    logic held_nxt, valid_nxt, hit;
    assign row_lo = !rs[0] ? 2'd0 : !rs[1] ? 2'd1 : !rs[2] ? 2'd2 : 2'd3;
    assign hit = !rs[row];
    always_ff @(posedge clk) begin
        if (!reset) begin
            rows_meta <= 4'hF;
            rs        <= 4'hF;
            state     <= SCAN;
            col_idx   <= 2'd0;
            cols_n    <= 4'b1110;
            cnt       <= '0;
            row       <= 2'd0;
            key_code  <= 4'd0;
            key_valid <= 1'b0;
            key_held  <= 1'b0;
        end else begin
            rows_meta <= rows_n;
            rs        <= rows_meta;
            state     <= state_nxt;
            col_idx   <= col_nxt;
            cols_n    <= ~(4'b0001 << col_nxt);
            cnt       <= cnt_nxt;
            row       <= row_nxt;
            key_code  <= code_nxt;
            key_valid <= valid_nxt;
            key_held  <= held_nxt;
        end
    end
    always_comb begin
        state_nxt = state;
        col_nxt   = col_idx;
        cnt_nxt   = cnt;
        row_nxt   = row;
        code_nxt  = key_code;
        held_nxt  = key_held;
        valid_nxt = 1'b0;
        if (tick) begin
            case (state)
                SCAN:
                    if (rs == 4'hF) col_nxt = col_idx + 2'd1;
                    else begin
                        row_nxt   = row_lo;
                        cnt_nxt   = '0;
                        state_nxt = DEB_PRESS;
                    end
                DEB_PRESS:
                    if (!hit) begin
                        cnt_nxt   = '0;
                        state_nxt = SCAN;
                    end else if (cnt != LAST) cnt_nxt = cnt + CW'(1);
                    else begin
                        code_nxt  = {row, col_idx};
                        held_nxt  = 1'b1;
                        valid_nxt = 1'b1;
                        state_nxt = HELD;
                    end
                // Column stays frozen; other rows are deliberately ignored (no rollover).
                HELD:
                    if (!hit) begin
                        cnt_nxt   = '0;
                        state_nxt = DEB_REL;
                    end
                DEB_REL:
                    if (hit) begin
                        cnt_nxt   = '0;
                        state_nxt = HELD;
                    end else if (cnt != LAST) cnt_nxt = cnt + CW'(1);
                    else begin
                        held_nxt  = 1'b0;
                        col_nxt   = col_idx + 2'd1;
                        state_nxt = SCAN;
                    end
            endcase
        end
    end
endmodule

// File: tb/tb_keypad_scan_controller.sv
// tb_keypad_scan_controller: directed and random keypad sequences checked against a behavioural keypad model.
module tb_keypad_scan_controller;
    localparam int D = 4;
    logic clk = 1'b0, reset = 1'b0, tick = 1'b0;
    logic [3:0] rows_n, cols_n, key_code;
    logic key_valid, key_held;
    logic [15:0] pressed = '0;
    int n_chk = 0, n_pass = 0, n_fail = 0;
    int m_mode, m_col, m_row, m_streak, m_code;
    bit m_held, m_valid;

    keypad_scan_controller #(.DEBOUNCE_TICKS(D)) dut (
        .clk(clk), .reset(reset), .tick(tick), .rows_n(rows_n),
        .cols_n(cols_n), .key_code(key_code), .key_valid(key_valid), .key_held(key_held)
    );

    always #5 clk = ~clk;

    // A row reads low only when a pressed key on it sits in a driven-low column.
    always_comb
        for (int r = 0; r < 4; r++) rows_n[r] = ~|(pressed[r*4 +: 4] & ~cols_n);

    task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_mode = 0; m_col = 0; m_row = 0; m_streak = 0; m_code = 0; m_held = 0; m_valid = 0;
    endtask

    // Modes: 0 scanning, 1 confirming press, 2 held, 3 confirming release.
    task automatic model_tick();
        int f;
        bit down;
        m_valid = 0;
        f = -1;
        for (int r = 3; r >= 0; r--) if (pressed[r*4+m_col]) f = r;
        down = pressed[m_row*4+m_col];
        case (m_mode)
            0: if (f < 0) m_col = (m_col + 1) % 4;
               else begin m_row = f; m_streak = 0; m_mode = 1; end
            1: if (!down) m_mode = 0;
               else begin
                   m_streak++;
                   if (m_streak == D) begin
                       m_code = m_row * 4 + m_col; m_held = 1; m_valid = 1; m_mode = 2;
                   end
               end
            2: if (!down) begin m_streak = 0; m_mode = 3; end
            default: if (down) m_mode = 2;
               else begin
                   m_streak++;
                   if (m_streak == D) begin m_held = 0; m_col = (m_col + 1) % 4; m_mode = 0; end
               end
        endcase
    endtask

    task automatic check_all(input string ctx);
        logic [3:0] ec;
        ec = 4'b1111;
        ec[m_col] = 1'b0;
        chk({ctx, "_cols"}, cols_n, ec);
        chk({ctx, "_code"}, key_code, 4'(m_code));
        chk({ctx, "_held"}, {3'b0, key_held}, {3'b0, m_held});
        chk({ctx, "_valid"}, {3'b0, key_valid}, {3'b0, m_valid});
    endtask

    task automatic step();
        @(negedge clk);
        chk("valid_width", {3'b0, key_valid}, 4'h0);
        repeat (8) @(negedge clk);
        tick = 1'b1;
        model_tick();
        @(negedge clk);
        tick = 1'b0;
        check_all("tick");
    endtask

    initial begin
        model_reset();
        repeat (3) @(negedge clk);
        reset = 1'b1;
        check_all("reset");
        repeat (8) step();
        pressed[9] = 1'b1;
        for (int i = 0; i < 12 && !m_held; i++) step();
        chk("press_code", key_code, 4'd9);
        pressed = '0;
        step();
        pressed[9] = 1'b1;
        step();
        step();
        chk("glitch_held", {3'b0, key_held}, 4'h1);
        pressed[1] = 1'b1;
        repeat (3) step();
        chk("rollover_code", key_code, 4'd9);
        pressed = '0;
        repeat (5) step();
        chk("rel_cols", cols_n, 4'b1011);
        chk("rel_held", {3'b0, key_held}, 4'h0);
        pressed[12] = 1'b1;
        for (int i = 0; i < 8 && m_mode != 1; i++) step();
        repeat (2) step();
        pressed = '0;
        repeat (3) step();
        chk("bounce_held", {3'b0, key_held}, 4'h0);
        pressed[6] = 1'b1;
        pressed[14] = 1'b1;
        for (int i = 0; i < 12 && !m_held; i++) step();
        chk("prio_code", key_code, 4'd6);
        pressed = '0;
        repeat (6) step();
        pressed[3] = 1'b1;
        for (int i = 0; i < 8 && m_mode != 1; i++) step();
        step();
        repeat (9) @(negedge clk);
        tick = 1'b1;
        reset = 1'b0;
        @(negedge clk);
        tick = 1'b0;
        reset = 1'b1;
        model_reset();
        check_all("mid_reset");
        for (int i = 0; i < 12 && !m_held; i++) step();
        chk("after_reset_code", key_code, 4'd3);
        pressed = '0;
        repeat (6) step();
        for (int i = 0; i < 60; i++) begin
            if ($urandom_range(0, 2) == 0)
                case ($urandom_range(0, 3))
                    0: pressed = '0;
                    1: begin pressed = '0; pressed[$urandom_range(0, 15)] = 1'b1; end
                    2: begin pressed = '0; pressed[$urandom_range(0, 15)] = 1'b1; pressed[$urandom_range(0, 15)] = 1'b1; end
                    default: ;
                endcase
            step();
        end
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
